divrem: RTL and testbench



---
 rtl/divrem.sv | 130 +++++++++++++
 tb/tb_divrem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/divrem.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Optional macro DIVREM_EARLY_OUT_EN sends divide-by-zero and signed overflow straight to FIX.
module divrem (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        ready,
    output logic [31:0] rd,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, next;
    logic [4:0]  cnt;
    logic        remop;
    logic [31:0] orig;
    logic [31:0] divr;
    logic [31:0] quo;
    logic [32:0] rem;
    logic        neg1, neg2, dz, ovf;

    logic        sgnop;
    logic [31:0] mag1, mag2;
    logic        accdz, accovf;
    logic [33:0] shifted, diff;
    logic [31:0] qres, rres, result;

    assign ready = (state == IDLE);

    // Operand decode at accept: magnitudes for signed ops, raw values otherwise.
    always_comb begin
        sgnop  = ~op[0];
        mag1   = (sgnop && rs1[31]) ? -rs1 : rs1;
        mag2   = (sgnop && rs2[31]) ? -rs2 : rs2;
        accdz  = (rs2 == 32'h0);
        accovf = sgnop && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    end

    // A borrow out of bit 33 marks a failed trial subtraction.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {2'b00, divr};
    end

    always_comb begin
        qres = (neg1 ^ neg2) ? -quo : quo;
        rres = neg1 ? -rem[31:0] : rem[31:0];
        if (dz) begin
            qres = 32'hFFFF_FFFF;
            rres = orig;
        end else if (ovf) begin
            qres = 32'h8000_0000;
            rres = 32'h0;
        end
        result = remop ? rres : qres;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef DIVREM_EARLY_OUT_EN
                    next = (accdz || accovf) ? FIX : CALC;
`else
                    next = CALC;
`endif
                end
            end
            CALC:    if (cnt == 5'd31) next = FIX;
            FIX:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= 5'd0;
            remop <= 1'b0;
            orig  <= 32'h0;
            divr  <= 32'h0;
            quo   <= 32'h0;
            rem   <= 33'h0;
            neg1  <= 1'b0;
            neg2  <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
            rd    <= 32'h0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remop <= op[1];
                        orig  <= rs1;
                        divr  <= mag2;
                        quo   <= mag1;
                        rem   <= 33'h0;
                        cnt   <= 5'd0;
                        neg1  <= sgnop & rs1[31];
                        neg2  <= sgnop & rs2[31];
                        dz    <= accdz;
                        ovf   <= accovf;
                    end
                end
                CALC: begin
                    rem <= diff[33] ? shifted[32:0] : diff[32:0];
                    quo <= {quo[30:0], ~diff[33]};
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    rd    <= result;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divrem.sv
// Directed self-checking bench for divrem: vector table plus handshake and reset sequences.
module tb_divrem;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        ready;
    logic [31:0] rd;
    logic        valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

`ifdef DIVREM_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
        string       name;
    } vec_t;

    vec_t vecs[20];

    divrem dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .op    (op),
        .rs1   (rs1),
        .rs2   (rs2),
        .ready (ready),
        .rd    (rd),
        .valid (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op from idle and waits (bounded) for its valid pulse.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] res, output int acc);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
        lat   = 0;
        res   = 32'hDEAD_BEEF;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                lat = i;
                res = rd;
                break;
            end
        end
    endtask

    int          lat, acc, acc2, nv;
    logic [31:0] res;

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, "divu_100_7"};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, "remu_100_7"};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, "div_m7_2"};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, "rem_m7_2"};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, "rem_7_m2"};
        vecs[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "div_5_0"};
        vecs[6]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1'b1, "rem_5_0"};
        vecs[7]  = '{2'b11, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1'b1, "remu_max_0"};
        vecs[8]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "divu_5_0"};
        vecs[9]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "div_ovf"};
        vecs[10] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b1, "rem_ovf"};
        vecs[11] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0, "divu_big"};
        vecs[12] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, "remu_big"};
        vecs[13] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, "div_min_1"};
        vecs[14] = '{2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, "div_100_m7"};
        vecs[15] = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0, "rem_m100_7"};
        vecs[16] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, "divu_max_1"};
        vecs[17] = '{2'b11, 32'hFFFF_FFFF,  32'd10,         32'd5,          1'b0, "remu_max_10"};
        vecs[18] = '{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          1'b0, "div_m7_m2"};
        vecs[19] = '{2'b11, 32'h1234_5678,  32'h0000_1000,  32'h0000_0678,  1'b0, "remu_mask"};

        #12;
        checkOutput("reset_ready", {31'b0, ready}, 32'd1);
        checkOutput("reset_valid", {31'b0, valid}, 32'd0);
        checkOutput("reset_rd", rd, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, acc);
            checkOutput({vecs[i].name, "_rd"}, res, vecs[i].exp);
            checkOutput({vecs[i].name, "_lat"}, lat, vecs[i].special ? SPECIAL_LAT : 33);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_vclr"}, {31'b0, valid}, 32'd0);
        end

        // Back-to-back: second start is raised during the first valid cycle.
        applyStimulus(2'b01, 32'd1000, 32'd3, lat, res, acc);
        checkOutput("b2b_first_rd", res, 32'd333);
        applyStimulus(2'b11, 32'd1000, 32'd3, lat, res, acc2);
        checkOutput("b2b_second_rd", res, 32'd1);
        checkOutput("b2b_spacing", acc2 - acc, 32'd34);

        // start held high with changing operands while busy.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        rs1   = 32'd1000;
        rs2   = 32'd7;
        @(posedge clk);
        #1;
        nv  = 0;
        lat = 0;
        res = 32'h0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            start = (i <= 32);
            rs1   = $urandom;
            rs2   = $urandom;
            op    = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            if (i == 10) checkOutput("hold_busy_ready", {31'b0, ready}, 32'd0);
            if (valid) begin
                nv++;
                lat = i;
                res = rd;
            end
        end
        start = 1'b0;
        checkOutput("hold_valid_count", nv, 32'd1);
        checkOutput("hold_lat", lat, 32'd33);
        checkOutput("hold_rd", res, 32'd142);

        // Reset mid-CALC discards the operation.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        rs1   = 32'd12345;
        rs2   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_mid_ready", {31'b0, ready}, 32'd1);
        checkOutput("rst_mid_valid", {31'b0, valid}, 32'd0);
        checkOutput("rst_mid_rd", rd, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        checkOutput("rst_no_stale_valid", nv, 32'd0);

        applyStimulus(2'b01, 32'd1000, 32'd10, lat, res, acc);
        checkOutput("post_rst_rd", res, 32'd100);
        checkOutput("post_rst_lat", lat, 32'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
